// File: rtl/gpu_vram_wb.sv
// gpu_vram_wb: Wishbone slave for the 1bpp framebuffer RAM. The RAM has one port,
// and the scanout read port takes it first.
module gpu_vram_wb #(
   parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
   parameter int          DEPTH_WORDS = 6144,
   parameter int          ADDR_W      = 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [3:0]        wb_sel_i,
   input  logic [31:0]       wb_adr_i,
   input  logic [31:0]       wb_dat_i,
   output logic              wb_ack_o,
   output logic [31:0]       wb_dat_o,
   input  logic              vid_req_i,
   input  logic [ADDR_W-1:0] vid_adr_i,
   output logic [31:0]       vid_dat_o,
   output logic              vid_vld_o,
   output logic              oor_o
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_ACK} state_t;

   localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * 4);
   localparam logic [31:0] WIN_WORDS = 32'(DEPTH_WORDS);

   state_t            state_q, state_d;
   logic              run_q;
   logic [31:0]       mem [DEPTH_WORDS];
   logic [31:0]       ram_q;
   logic [31:0]       off;
   logic [ADDR_W-1:0] wb_idx, ram_adr;
   logic              in_range, vid_in_range, req, accept, ram_we, ram_re;
   logic              rd_oor_q, vid_inr_q;

   assign off          = wb_adr_i - BASE_ADDR;
   assign in_range     = (wb_adr_i >= BASE_ADDR) && (off < WIN_BYTES);
   assign wb_idx       = off[ADDR_W+1:2];
   assign vid_in_range = 32'(vid_adr_i) < WIN_WORDS;
   assign req          = wb_cyc_i & wb_stb_i & ~wb_ack_o;

   // Out-of-range requests never touch the RAM, so they skip the scanout wait.
   // run_q holds off acceptance until the first edge after reset is released,
   // so a write can only land on a clean accept edge.
   assign accept  = run_q && (state_q == S_IDLE) && req && (!in_range || !vid_req_i);
   assign ram_we  = accept & wb_we_i & in_range;
   assign ram_re  = vid_req_i | (accept & ~wb_we_i & in_range);
   assign ram_adr = vid_req_i ? (vid_in_range ? vid_adr_i : '0) : wb_idx;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values, independent of the order the processes are evaluated.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
      end
   end

   // NOTE: next-state gets its default before the case, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = wb_we_i ? S_ACK : S_RD;
         S_RD:    state_d = wb_cyc_i ? S_ACK : S_IDLE;
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: the storage array has no reset branch. Framebuffer contents survive
   // reset, and leaving out the reset lets this map onto block RAM.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wb_sel_i[b]) mem[ram_adr][8*b +: 8] <= wb_dat_i[8*b +: 8];
         end
      end
      if (ram_re) ram_q <= mem[ram_adr];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_dat_o  <= '0;
         rd_oor_q  <= 1'b0;
         oor_o     <= 1'b0;
         vid_vld_o <= 1'b0;
         vid_inr_q <= 1'b0;
      end else begin
         vid_vld_o <= vid_req_i;
         vid_inr_q <= vid_in_range;
         if (accept) begin
            rd_oor_q <= !in_range;
            if (!in_range) oor_o <= 1'b1;
         end
         // ram_q still holds the word fetched on the accept edge, even when
         // scanout reloads it on this same edge.
         if (state_q == S_RD && wb_cyc_i) wb_dat_o <= rd_oor_q ? '0 : ram_q;
      end
   end

   assign wb_ack_o  = (state_q == S_ACK);
   assign vid_dat_o = (vid_vld_o && vid_inr_q) ? ram_q : '0;

endmodule

// File: tb/tb_gpu_vram_wb.sv
// Testbench for gpu_vram_wb. The stimulus thread queues the expected acks and
// scanout words; a monitor thread compares them as the DUT presents them.
module tb_gpu_vram_wb;

   localparam int ADDR_W = 13;

   logic              clk = 1'b0;
   logic              rst;
   logic              wb_cyc_i, wb_stb_i, wb_we_i;
   logic [3:0]        wb_sel_i;
   logic [31:0]       wb_adr_i, wb_dat_i;
   logic              wb_ack_o;
   logic [31:0]       wb_dat_o;
   logic              vid_req_i;
   logic [ADDR_W-1:0] vid_adr_i;
   logic [31:0]       vid_dat_o;
   logic              vid_vld_o;
   logic              oor_o;

   gpu_vram_wb dut (
      .clk       (clk),
      .rst       (rst),
      .wb_cyc_i  (wb_cyc_i),
      .wb_stb_i  (wb_stb_i),
      .wb_we_i   (wb_we_i),
      .wb_sel_i  (wb_sel_i),
      .wb_adr_i  (wb_adr_i),
      .wb_dat_i  (wb_dat_i),
      .wb_ack_o  (wb_ack_o),
      .wb_dat_o  (wb_dat_o),
      .vid_req_i (vid_req_i),
      .vid_adr_i (vid_adr_i),
      .vid_dat_o (vid_dat_o),
      .vid_vld_o (vid_vld_o),
      .oor_o     (oor_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        chk_data;
      int          cyc;
      int          id;
   } exp_t;

   exp_t wb_q[$];
   exp_t vid_q[$];
   exp_t wb_e, vid_e;
   int   tests = 0;
   int   fails = 0;
   int   cyc_cnt = 0;
   int   next_id = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      if (wb_ack_o) begin
         if (wb_q.size() == 0) begin
            check("wb_unexpected_ack", 32'(wb_ack_o), 32'h0);
         end else begin
            wb_e = wb_q.pop_front();
            check($sformatf("wb_ack_cycle#%0d", wb_e.id), 32'(cyc_cnt), 32'(wb_e.cyc));
            if (wb_e.chk_data) check($sformatf("wb_rd_data#%0d", wb_e.id), wb_dat_o, wb_e.data);
         end
      end
      if (vid_vld_o) begin
         if (vid_q.size() == 0) begin
            check("vid_unexpected_vld", 32'(vid_vld_o), 32'h0);
         end else begin
            vid_e = vid_q.pop_front();
            check($sformatf("vid_cycle#%0d", vid_e.id), 32'(cyc_cnt), 32'(vid_e.cyc));
            check($sformatf("vid_data#%0d", vid_e.id), vid_dat_o, vid_e.data);
         end
      end
   end

   // One Wishbone access. If stall > 0, scanout of word 16 is held for stall
   // cycles, starting in the same cycle as the request.
   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [31:0] exp, input int stall,
                          input logic [31:0] vexp);
      exp_t e;
      int   n;
      int   id;
      @(negedge clk);
      id = next_id;
      next_id++;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = we;
      wb_adr_i = adr;
      wb_dat_i = dat;
      wb_sel_i = sel;
      e.data     = exp;
      e.chk_data = !we;
      e.cyc      = cyc_cnt + (we ? 1 : 2) + stall;
      e.id       = id;
      wb_q.push_back(e);
      if (stall > 0) begin
         vid_req_i = 1'b1;
         vid_adr_i = 13'd16;
         for (int i = 0; i < stall; i++) begin
            e.data     = vexp;
            e.chk_data = 1'b1;
            e.cyc      = cyc_cnt + 1 + i;
            vid_q.push_back(e);
         end
         repeat (stall) @(negedge clk);
         vid_req_i = 1'b0;
      end
      n = 0;
      while (!wb_ack_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!wb_ack_o) check($sformatf("wb_ack_timeout#%0d", id), 32'(wb_ack_o), 32'h1);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   task automatic vid_read(input logic [ADDR_W-1:0] adr, input logic [31:0] exp);
      exp_t e;
      @(negedge clk);
      vid_req_i  = 1'b1;
      vid_adr_i  = adr;
      e.data     = exp;
      e.chk_data = 1'b1;
      e.cyc      = cyc_cnt + 1;
      e.id       = next_id;
      next_id++;
      vid_q.push_back(e);
      @(negedge clk);
      vid_req_i = 1'b0;
      @(negedge clk);
      check("vid_vld_drops", 32'(vid_vld_o), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before 200000");
      $fatal(1);
   end

   initial begin
      rst       = 1'b0;
      wb_cyc_i  = 1'b0;
      wb_stb_i  = 1'b0;
      wb_we_i   = 1'b0;
      wb_sel_i  = 4'h0;
      wb_adr_i  = 32'h0;
      wb_dat_i  = 32'h0;
      vid_req_i = 1'b0;
      vid_adr_i = '0;
      repeat (3) @(negedge clk);
      check("rst_ack", 32'(wb_ack_o), 32'h0);
      check("rst_wb_dat", wb_dat_o, 32'h0);
      check("rst_vid_vld", 32'(vid_vld_o), 32'h0);
      check("rst_vid_dat", vid_dat_o, 32'h0);
      check("rst_oor", 32'(oor_o), 32'h0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Basic write then read-back of word 16.
      wb_xfer(1'b1, 32'h2000_0040, 32'hA5A5_F00F, 4'hF, 32'h0, 0, 32'h0);
      wb_xfer(1'b0, 32'h2000_0040, 32'h0, 4'hF, 32'hA5A5_F00F, 0, 32'h0);

      // Byte mask, then a write with no byte enables.
      wb_xfer(1'b1, 32'h2000_0040, 32'hFFFF_FFFF, 4'hF, 32'h0, 0, 32'h0);
      wb_xfer(1'b1, 32'h2000_0040, 32'h0000_0000, 4'b0101, 32'h0, 0, 32'h0);
      wb_xfer(1'b0, 32'h2000_0040, 32'h0, 4'hF, 32'hFF00_FF00, 0, 32'h0);
      wb_xfer(1'b1, 32'h2000_0040, 32'h1234_5678, 4'h0, 32'h0, 0, 32'h0);
      wb_xfer(1'b0, 32'h2000_0040, 32'h0, 4'hF, 32'hFF00_FF00, 0, 32'h0);

      // Scanout collision: a read held off for 3 cycles, then standalone scanout reads.
      wb_xfer(1'b0, 32'h2000_0040, 32'h0, 4'hF, 32'hFF00_FF00, 3, 32'hFF00_FF00);
      vid_read(13'd16, 32'hFF00_FF00);
      vid_read(13'd6144, 32'h0);

      // Last in-range word, then out-of-range accesses.
      wb_xfer(1'b1, 32'h2000_5FFC, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 32'h0);
      wb_xfer(1'b0, 32'h2000_5FFC, 32'h0, 4'hF, 32'hDEAD_BEEF, 0, 32'h0);
      check("oor_before", 32'(oor_o), 32'h0);
      wb_xfer(1'b0, 32'h2000_6000, 32'h0, 4'hF, 32'h0, 0, 32'h0);
      check("oor_after_read", 32'(oor_o), 32'h1);
      wb_xfer(1'b1, 32'h1FFF_FFFC, 32'h0, 4'hF, 32'h0, 0, 32'h0);
      wb_xfer(1'b0, 32'h2000_5FFC, 32'h0, 4'hF, 32'hDEAD_BEEF, 0, 32'h0);
      wb_xfer(1'b0, 32'h2000_0040, 32'h0, 4'hF, 32'hFF00_FF00, 0, 32'h0);
      check("oor_sticky", 32'(oor_o), 32'h1);

      // Blitter-style fill: 2 lines x 2 words; word 2 must survive.
      wb_xfer(1'b1, 32'h2000_0008, 32'h0BAD_F00D, 4'hF, 32'h0, 0, 32'h0);
      for (int l = 0; l < 2; l++) begin
         for (int w = 0; w < 2; w++) begin
            wb_xfer(1'b1, 32'h2000_0000 + 32'(l * 64 + w * 4), 32'h5555_5555, 4'hF, 32'h0, 0, 32'h0);
         end
      end
      wb_xfer(1'b0, 32'h2000_0000, 32'h0, 4'hF, 32'h5555_5555, 0, 32'h0);
      wb_xfer(1'b0, 32'h2000_0004, 32'h0, 4'hF, 32'h5555_5555, 0, 32'h0);
      wb_xfer(1'b0, 32'h2000_0040, 32'h0, 4'hF, 32'h5555_5555, 0, 32'h0);
      wb_xfer(1'b0, 32'h2000_0044, 32'h0, 4'hF, 32'h5555_5555, 0, 32'h0);
      wb_xfer(1'b0, 32'h2000_0008, 32'h0, 4'hF, 32'h0BAD_F00D, 0, 32'h0);

      // Abort: cyc drops while the read is in flight, so no ack may follow.
      @(negedge clk);
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = 1'b0;
      wb_adr_i = 32'h2000_0040;
      @(negedge clk);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("abort_no_ack", 32'(wb_ack_o), 32'h0);
      end
      wb_xfer(1'b0, 32'h2000_0040, 32'h0, 4'hF, 32'h5555_5555, 0, 32'h0);

      // Async reset while the read is in flight.
      check("oor_before_rst", 32'(oor_o), 32'h1);
      @(negedge clk);
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = 1'b0;
      wb_adr_i = 32'h2000_0040;
      @(negedge clk);
      rst      = 1'b0;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      #1;
      check("rst_async_oor", 32'(oor_o), 32'h0);
      check("rst_async_ack", 32'(wb_ack_o), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("rst_no_ack", 32'(wb_ack_o), 32'h0);
      end
      check("oor_after_rst", 32'(oor_o), 32'h0);
      wb_xfer(1'b0, 32'h2000_0040, 32'h0, 4'hF, 32'h5555_5555, 0, 32'h0);

      repeat (3) @(negedge clk);
      check("wb_queue_drained", 32'(wb_q.size()), 32'h0);
      check("vid_queue_drained", 32'(vid_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
